// File: rtl/sr_latch_pulse_sequencer_if.sv
// Request/grant handshake between the set/clear requesters and the SR latch pulse sequencer.
interface sr_latch_pulse_sequencer_if;
    logic set_req;
    logic clr_req;
    logic set_ack;
    logic clr_ack;
    logic busy;

    modport master (
        output set_req,
        output clr_req,
        input  set_ack,
        input  clr_ack,
        input  busy
    );

    modport slave (
        input  set_req,
        input  clr_req,
        output set_ack,
        output clr_ack,
        output busy
    );
endinterface

// File: rtl/sr_latch_pulse_sequencer.sv
// Sequences fixed-width S/R pulses with a guard gap into an external SR latch,
// arbitrates set/clear requests round-robin and checks latch feedback after each pulse.
module sr_latch_pulse_sequencer #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    sr_latch_pulse_sequencer_if.slave      req_bus,
    output logic                           s_out,
    output logic                           r_out,
    output logic                           s_n_out,
    output logic                           r_n_out,
    input  logic                           q_fb,
    output logic                           q_exp,
    output logic                           err,
    input  logic                           err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CLR = 1'b0,
        GRANT_SET = 1'b1
    } grant_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_W - 1);

    state_t     state_r, state_s;
    grant_t     last_grant_r, last_grant_s;
    logic [7:0] cnt_r, cnt_s;
    logic       s_r, s_s;
    logic       r_r, r_s;
    logic       set_ack_r, set_ack_s;
    logic       clr_ack_r, clr_ack_s;
    logic       busy_r, busy_s;
    logic       q_exp_r, q_exp_s;
    logic       err_r, err_s;
    logic       mismatch_s;
    logic       q_meta_r, q_sync_r;

    // Next-state, counter and next-output decode
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        s_s          = 1'b0;
        r_s          = 1'b0;
        set_ack_s    = 1'b0;
        clr_ack_s    = 1'b0;
        q_exp_s      = q_exp_r;
        mismatch_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A tie goes to whichever side was not granted last
                if (req_bus.set_req && (!req_bus.clr_req || (last_grant_r == GRANT_CLR))) begin
                    state_s      = ST_PULSE;
                    cnt_s        = PULSE_LOAD;
                    s_s          = 1'b1;
                    set_ack_s    = 1'b1;
                    q_exp_s      = 1'b1;
                    last_grant_s = GRANT_SET;
                end else if (req_bus.clr_req) begin
                    state_s      = ST_PULSE;
                    cnt_s        = PULSE_LOAD;
                    r_s          = 1'b1;
                    clr_ack_s    = 1'b1;
                    q_exp_s      = 1'b0;
                    last_grant_s = GRANT_CLR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == 8'd0) begin
                    state_s = ST_GAP;
                    cnt_s   = GAP_LOAD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                    s_s   = s_r;
                    r_s   = r_r;
                end
            end
            ST_GAP: begin
                if (cnt_r == 8'd0) begin
                    state_s    = ST_IDLE;
                    mismatch_s = (q_sync_r != q_exp_r);
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        if (mismatch_s) begin
            err_s = 1'b1;
        end else if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counter, arbitration history and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= GRANT_CLR;
            cnt_r        <= 8'd0;
            s_r          <= 1'b0;
            r_r          <= 1'b0;
            set_ack_r    <= 1'b0;
            clr_ack_r    <= 1'b0;
            busy_r       <= 1'b0;
            q_exp_r      <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
            s_r          <= s_s;
            r_r          <= r_s;
            set_ack_r    <= set_ack_s;
            clr_ack_r    <= clr_ack_s;
            busy_r       <= busy_s;
            q_exp_r      <= q_exp_s;
            err_r        <= err_s;
        end
    end

    // Two-flop synchronizer for the asynchronous latch feedback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_meta_r <= 1'b0;
            q_sync_r <= 1'b0;
        end else begin
            q_meta_r <= q_fb;
            q_sync_r <= q_meta_r;
        end
    end

    assign s_out           = s_r;
    assign r_out           = r_r;
    assign s_n_out         = ~s_r;
    assign r_n_out         = ~r_r;
    assign req_bus.set_ack = set_ack_r;
    assign req_bus.clr_ack = clr_ack_r;
    assign req_bus.busy    = busy_r;
    assign q_exp           = q_exp_r;
    assign err             = err_r;

endmodule
